// File: rtl/branch_target_buffer_if.sv
// Fetch-lookup, branch-resolution update and redirect signals of the branch target buffer.
// The pipeline side drives through master; the BTB consumes through slave.
interface branch_target_buffer_if;
   logic        stg_ena;
   logic        flush_req;
   logic [31:0] fetch_pc;
   logic        pred_hit;
   logic [1:0]  pred_counter;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic [1:0]  upd_flag;
   logic [31:0] upd_fetch_pc;
   logic [1:0]  upd_counter;
   logic        upd_hit;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        btb_ready;

   modport master (
      output stg_ena, flush_req, fetch_pc,
      output upd_pc, upd_target, upd_flag, upd_fetch_pc, upd_counter, upd_hit,
      input  pred_hit, pred_counter, pred_taken, pred_target,
      input  redirect_valid, redirect_pc, btb_ready
   );

   modport slave (
      input  stg_ena, flush_req, fetch_pc,
      input  upd_pc, upd_target, upd_flag, upd_fetch_pc, upd_counter, upd_hit,
      output pred_hit, pred_counter, pred_taken, pred_target,
      output redirect_valid, redirect_pc, btb_ready
   );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters, a walking
// invalidation after reset or flush, and a registered mispredict redirect.
module branch_target_buffer #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4
) (
   input logic                stg_clk,
   input logic                reset,
   branch_target_buffer_if.slave bus
);
   localparam int TAG_W = 32 - IDX_W - 2;

   typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      if (c == 2'b11) return 2'b11;
      else            return c + 2'b01;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      if (c == 2'b00) return 2'b00;
      else            return c - 2'b01;
   endfunction

   state_t             state_r, state_s;
   logic [IDX_W-1:0]   walk_idx_r, walk_idx_s;
   logic [ENTRIES-1:0] valid_r;
   logic [TAG_W-1:0]   tag_r    [ENTRIES];
   logic [31:0]        target_r [ENTRIES];
   logic [1:0]         ctr_r    [ENTRIES];
   logic               redirect_valid_r;
   logic [31:0]        redirect_pc_r;
   logic               btb_ready_r;

   logic [IDX_W-1:0]   look_idx_s, upd_idx_s;
   logic [TAG_W-1:0]   look_tag_s, upd_tag_s;
   logic               hit_s, taken_s;
   logic [1:0]         ctr_s;
   logic               upd_en_s, upd_taken_s, upd_not_taken_s, upd_no_branch_s;
   logic [31:0]        actual_next_s;

   assign look_idx_s = bus.fetch_pc[IDX_W+1:2];
   assign look_tag_s = bus.fetch_pc[31:IDX_W+2];
   assign upd_idx_s  = bus.upd_pc[IDX_W+1:2];
   assign upd_tag_s  = bus.upd_pc[31:IDX_W+2];

   // Walk state machine: CLEAR visits every index once, flush from READY restarts the walk.
   always_comb begin
      state_s    = state_r;
      walk_idx_s = walk_idx_r;
      case (state_r)
         ST_CLEAR: begin
            walk_idx_s = walk_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            if (walk_idx_r == IDX_W'(ENTRIES - 1)) state_s = ST_READY;
            else                                   state_s = ST_CLEAR;
         end
         ST_READY: begin
            if (bus.flush_req) begin
               state_s    = ST_CLEAR;
               walk_idx_s = {IDX_W{1'b0}};
            end else begin
               state_s    = ST_READY;
            end
         end
         default: begin
            state_s    = ST_CLEAR;
            walk_idx_s = {IDX_W{1'b0}};
         end
      endcase
   end

   // Fetch-side lookup; entries are invisible while the walk is running.
   always_comb begin
      hit_s   = 1'b0;
      ctr_s   = 2'b00;
      if ((state_r == ST_READY) && valid_r[look_idx_s] && (tag_r[look_idx_s] == look_tag_s)) begin
         hit_s = 1'b1;
         ctr_s = ctr_r[look_idx_s];
      end else begin
         hit_s = 1'b0;
         ctr_s = 2'b00;
      end
      taken_s = hit_s & ctr_s[1];
   end

   assign bus.pred_hit     = hit_s;
   assign bus.pred_counter = ctr_s;
   assign bus.pred_taken   = taken_s;
   assign bus.pred_target  = taken_s ? target_r[look_idx_s] : (bus.fetch_pc + 32'd4);

   // Flag 2'b11 is deliberately decoded as "no branch".
   always_comb begin
      upd_en_s        = (state_r == ST_READY) & bus.stg_ena & ~bus.flush_req;
      upd_taken_s     = (bus.upd_flag == 2'b10);
      upd_not_taken_s = (bus.upd_flag == 2'b01);
      upd_no_branch_s = ~upd_taken_s & ~upd_not_taken_s;
      actual_next_s   = upd_taken_s ? bus.upd_target : (bus.upd_pc + 32'd4);
   end

   // Control registers: FSM, walk pointer, ready flag and redirect.
   always_ff @(posedge stg_clk or negedge reset) begin
      if (!reset) begin
         state_r          <= ST_CLEAR;
         walk_idx_r       <= {IDX_W{1'b0}};
         btb_ready_r      <= 1'b0;
         redirect_valid_r <= 1'b0;
         redirect_pc_r    <= 32'd0;
      end else begin
         state_r     <= state_s;
         walk_idx_r  <= walk_idx_s;
         btb_ready_r <= (state_s == ST_READY);
         if (upd_en_s) begin
            redirect_valid_r <= (actual_next_s != bus.upd_fetch_pc);
            redirect_pc_r    <= actual_next_s;
         end else begin
            redirect_valid_r <= 1'b0;
         end
      end
   end

   // Valid bits: walking clear has priority, then allocation or alias eviction.
   always_ff @(posedge stg_clk or negedge reset) begin
      if (!reset) begin
         valid_r <= {ENTRIES{1'b0}};
      end else if (state_r == ST_CLEAR) begin
         valid_r[walk_idx_r] <= 1'b0;
      end else if (upd_en_s && upd_taken_s && !bus.upd_hit) begin
         valid_r[upd_idx_s] <= 1'b1;
      end else if (upd_en_s && upd_no_branch_s && bus.upd_hit) begin
         valid_r[upd_idx_s] <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   // Payload storage is qualified by valid_r, so it needs no reset.
   always_ff @(posedge stg_clk) begin
      if (upd_en_s && upd_taken_s) begin
         target_r[upd_idx_s] <= bus.upd_target;
         if (bus.upd_hit) begin
            ctr_r[upd_idx_s] <= sat_inc(bus.upd_counter);
         end else begin
            tag_r[upd_idx_s] <= upd_tag_s;
            ctr_r[upd_idx_s] <= 2'b10;
         end
      end else if (upd_en_s && upd_not_taken_s && bus.upd_hit) begin
         ctr_r[upd_idx_s] <= sat_dec(bus.upd_counter);
      end
   end

   assign bus.redirect_valid = redirect_valid_r;
   assign bus.redirect_pc    = redirect_pc_r;
   assign bus.btb_ready      = btb_ready_r;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed scoreboard bench for branch_target_buffer: the driver queues expected
// lookups, status and redirects; the negedge monitor pops and compares them.
module tb_branch_target_buffer;
   logic stg_clk = 1'b0;
   logic reset   = 1'b0;
   int   checks  = 0;
   int   errors  = 0;

   typedef struct {
      logic        hit;
      logic [1:0]  ctr;
      logic        taken;
      logic [31:0] tgt;
   } look_t;

   typedef struct {
      logic        ready;
      logic        chk_r;
      logic        rvalid;
      logic [31:0] rpc;
   } stat_t;

   look_t       look_q  [$];
   stat_t       stat_q  [$];
   logic [31:0] redir_q [$];

   branch_target_buffer_if bus();

   branch_target_buffer #(.ENTRIES(16), .IDX_W(4)) dut (
      .stg_clk (stg_clk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 stg_clk = ~stg_clk;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: compare everything queued for this cycle, and every redirect pulse.
   always @(negedge stg_clk) begin
      look_t       le;
      stat_t       se;
      logic [31:0] rp;
      while (look_q.size() > 0) begin
         le = look_q.pop_front();
         cmp("pred_hit",     {31'd0, bus.pred_hit},     {31'd0, le.hit});
         cmp("pred_counter", {30'd0, bus.pred_counter}, {30'd0, le.ctr});
         cmp("pred_taken",   {31'd0, bus.pred_taken},   {31'd0, le.taken});
         cmp("pred_target",  bus.pred_target,           le.tgt);
      end
      while (stat_q.size() > 0) begin
         se = stat_q.pop_front();
         cmp("btb_ready", {31'd0, bus.btb_ready}, {31'd0, se.ready});
         if (se.chk_r) begin
            cmp("redirect_valid_level", {31'd0, bus.redirect_valid}, {31'd0, se.rvalid});
            cmp("redirect_pc_level",    bus.redirect_pc,             se.rpc);
         end
      end
      if (bus.redirect_valid === 1'b1) begin
         if (redir_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL redirect_unexpected got pc=%h expected no redirect", bus.redirect_pc);
         end else begin
            rp = redir_q.pop_front();
            cmp("redirect_pc", bus.redirect_pc, rp);
         end
      end
   end

   task automatic tick();
      @(posedge stg_clk);
      #1;
   endtask

   task automatic look(input logic [31:0] pc, input logic hit, input logic [1:0] ctr,
                       input logic taken, input logic [31:0] tgt);
      look_t e;
      bus.fetch_pc = pc;
      e.hit = hit; e.ctr = ctr; e.taken = taken; e.tgt = tgt;
      look_q.push_back(e);
   endtask

   task automatic stat(input logic ready, input logic chk_r, input logic rvalid, input logic [31:0] rpc);
      stat_t e;
      e.ready = ready; e.chk_r = chk_r; e.rvalid = rvalid; e.rpc = rpc;
      stat_q.push_back(e);
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] flag,
                      input logic [31:0] fnext, input logic [1:0] ctr, input logic hit,
                      input logic ena, input logic fl, input logic exp_rv, input logic [31:0] exp_rpc);
      bus.upd_pc       = pc;
      bus.upd_target   = tgt;
      bus.upd_flag     = flag;
      bus.upd_fetch_pc = fnext;
      bus.upd_counter  = ctr;
      bus.upd_hit      = hit;
      bus.stg_ena      = ena;
      bus.flush_req    = fl;
      if (exp_rv) redir_q.push_back(exp_rpc);
      tick();
      bus.stg_ena   = 1'b0;
      bus.flush_req = 1'b0;
      bus.upd_flag  = 2'b00;
      bus.upd_hit   = 1'b0;
   endtask

   initial begin
      bus.stg_ena = 1'b0; bus.flush_req = 1'b0; bus.fetch_pc = 32'h0;
      bus.upd_pc = 32'h0; bus.upd_target = 32'h0; bus.upd_flag = 2'b00;
      bus.upd_fetch_pc = 32'h0; bus.upd_counter = 2'b00; bus.upd_hit = 1'b0;

      // Reset values, then the 16-cycle walk.
      tick(); tick();
      stat(1'b0, 1'b1, 1'b0, 32'h0);
      look(32'h100, 1'b0, 2'b00, 1'b0, 32'h104);
      tick();
      reset = 1'b1;
      stat(1'b0, 1'b0, 1'b0, 32'h0);
      for (int k = 1; k <= 16; k++) begin
         tick();
         stat(k == 16, 1'b0, 1'b0, 32'h0);
         if (k == 8) look(32'h100, 1'b0, 2'b00, 1'b0, 32'h104);
      end

      // Allocation on a taken miss redirects to the target.
      upd(32'h100, 32'h200, 2'b10, 32'h104, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
      look(32'h100, 1'b1, 2'b10, 1'b1, 32'h200);

      // Counter training and saturation.
      upd(32'h100, 32'h200, 2'b10, 32'h200, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      look(32'h100, 1'b1, 2'b11, 1'b1, 32'h200);
      upd(32'h100, 32'h200, 2'b10, 32'h200, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      look(32'h100, 1'b1, 2'b11, 1'b1, 32'h200);
      upd(32'h100, 32'h200, 2'b10, 32'h200, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      look(32'h100, 1'b1, 2'b11, 1'b1, 32'h200);
      upd(32'h100, 32'h200, 2'b01, 32'h104, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      look(32'h100, 1'b1, 2'b10, 1'b1, 32'h200);
      upd(32'h100, 32'h200, 2'b01, 32'h104, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      look(32'h100, 1'b1, 2'b01, 1'b0, 32'h104);
      upd(32'h100, 32'h200, 2'b01, 32'h104, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      look(32'h100, 1'b1, 2'b00, 1'b0, 32'h104);
      upd(32'h100, 32'h200, 2'b01, 32'h200, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h104);
      look(32'h100, 1'b1, 2'b00, 1'b0, 32'h104);
      upd(32'hFFFF_FFFC, 32'h0, 2'b01, 32'h4, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);

      // Index aliasing and no-branch eviction (flag 00 and 11).
      upd(32'h140, 32'h300, 2'b10, 32'h144, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300);
      look(32'h100, 1'b0, 2'b00, 1'b0, 32'h104);
      tick();
      look(32'h140, 1'b1, 2'b10, 1'b1, 32'h300);
      upd(32'h140, 32'h0, 2'b00, 32'h144, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      look(32'h140, 1'b0, 2'b00, 1'b0, 32'h144);
      upd(32'h208, 32'h400, 2'b10, 32'h20C, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h400);
      look(32'h208, 1'b1, 2'b10, 1'b1, 32'h400);
      upd(32'h208, 32'h0, 2'b11, 32'h20C, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      look(32'h208, 1'b0, 2'b00, 1'b0, 32'h20C);

      // Flush with a same-cycle update: update dropped, walk restarts.
      upd(32'h100, 32'h200, 2'b10, 32'h200, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      look(32'h100, 1'b1, 2'b10, 1'b1, 32'h200);
      upd(32'h30C, 32'h500, 2'b10, 32'h310, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      stat(1'b0, 1'b0, 1'b0, 32'h0);
      look(32'h100, 1'b0, 2'b00, 1'b0, 32'h104);
      for (int k = 1; k <= 16; k++) begin
         tick();
         stat(k == 16, 1'b0, 1'b0, 32'h0);
      end
      look(32'h100, 1'b0, 2'b00, 1'b0, 32'h104);
      tick();
      look(32'h30C, 1'b0, 2'b00, 1'b0, 32'h310);
      tick();

      // Stage disabled: no write, no redirect, redirect_pc holds.
      upd(32'h100, 32'h600, 2'b10, 32'h104, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      look(32'h100, 1'b0, 2'b00, 1'b0, 32'h104);
      tick();
      stat(1'b1, 1'b1, 1'b0, 32'h200);
      tick(); tick(); tick();

      cmp("redirects_outstanding", redir_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
